frame_sequencer: RTL
====================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 16: payload words per frame (legal 1..65535).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: idle cycles between frames (legal 0..65535).
REQ-003 The block SHALL have parameter HDR_TAG, default 16'hFACE: upper half of every header word.
REQ-004 Port clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port run  input  1  level; high = keep producing frames.
REQ-007 Port full  input  1  downstream FIFO full flag.
REQ-008 Port frame_count  input  32  current value from the frame counter instance.
REQ-009 Port wr_en  output  1  FIFO write strobe.
REQ-010 Port din  output  32  FIFO write data, valid when wr_en=1.
REQ-011 Port frame_inc  output  1  one-cycle pulse to the frame counter enable.
REQ-012 Port busy  output  1  high in any state other than IDLE.
REQ-013 Port stall_cnt  output  32  count of cycles a write was blocked by full.

Function
REQ-014 The FSM SHALL have states IDLE, HDR, DATA and GAP.
REQ-015 IDLE: if run=1, the next state SHALL be HDR; otherwise the FSM SHALL stay in IDLE.
REQ-016 wr_en SHALL be combinational: 1 iff state is HDR or DATA and full=0, so no write is ever issued while full=1.
REQ-017 HDR: din SHALL be {HDR_TAG, frame_count[15:0]}; on a cycle with wr_en=1, word_idx SHALL load 0 and the next state SHALL be DATA.
REQ-018 DATA: din SHALL be {frame_count[15:0], word_idx[15:0]}; each cycle with wr_en=1 SHALL increment word_idx.
REQ-019 On the DATA write with word_idx=FRAME_LEN-1, frame_inc SHALL be 1 in that same cycle, and the next state SHALL be GAP, or HDR/IDLE directly when GAP_CYCLES=0 (per REQ-020).
REQ-020 GAP: the FSM SHALL hold for exactly GAP_CYCLES cycles, then go to HDR if run=1, or to IDLE if run=0.
REQ-021 frame_inc SHALL be 0 in every other cycle and SHALL pulse exactly once per completed frame.
REQ-022 Latency: the header write SHALL occur no earlier than 1 cycle after run is sampled high in IDLE.
REQ-023 Deassertion of run mid-frame SHALL NOT truncate the frame; the FSM SHALL finish DATA and GAP, then enter IDLE.
REQ-024 full=1 in HDR or DATA SHALL hold state, word_idx and din stable, and SHALL increment stall_cnt by 1 per cycle.
REQ-025 stall_cnt SHALL saturate at 32'hFFFF_FFFF and SHALL NOT wrap.
REQ-026 A frame SHALL be exactly 1 header word plus FRAME_LEN payload words, with no other writes.
REQ-027 Because frame_count updates one cycle after frame_inc, the next header SHALL carry the incremented count.
REQ-028 frame_count[15:0] SHALL wrap naturally from 16'hFFFF to 0 in din with no special handling.
REQ-029 When full toggles in the same cycle as the last payload word, the word SHALL be written only when full=0, and frame_inc SHALL coincide with that write.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state IDLE, word_idx 0, gap counter 0, stall_cnt 0.
REQ-031 Under reset, wr_en, frame_inc and busy SHALL be 0; din SHALL be don't-care.
REQ-032 Reset mid-frame SHALL abandon the partial frame with no frame_inc pulse; after rst falls with run=1, the next frame SHALL start with a header.
REQ-033 rst SHALL take priority over run and full.

Verification
REQ-034 Defaults, frame_count starting at 0, run=1, full=0 -> din sequence 32'hFACE_0000, then 32'h0000_0000..32'h0000_000F; frame_inc with the 17th word; 4 idle cycles; next header 32'hFACE_0001.
REQ-035 full=1 for 5 cycles at payload word 3 -> din holds 32'h0000_0003 with wr_en=0; stall_cnt=5; the word is written once when full falls; no word is lost or duplicated.
REQ-036 run dropped during payload word 7 -> remaining words 8..15 are written, frame_inc pulses, 4 GAP cycles follow, then IDLE with busy=0.
REQ-037 rst pulsed at payload word 9 -> no frame_inc; stall_cnt=0; the restart emits a header with an unchanged frame_count.
REQ-038 GAP_CYCLES=0, FRAME_LEN=1 -> back-to-back frames with a write every cycle: header, word0, header, word0 ...; frame_inc every 2nd cycle.
REQ-039 frame_count=32'h0000_FFFF with a frame completed -> header 32'hFACE_FFFF, then the next header is 32'hFACE_0000.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame sequencer: emits header + FRAME_LEN payload words into a FIFO,
// then idles GAP_CYCLES cycles before the next frame while run is high.
module frame_sequencer #(
   parameter int unsigned FRAME_LEN  = 16,
   parameter int unsigned GAP_CYCLES = 4,
   parameter logic [15:0] HDR_TAG    = 16'hFACE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        full,
   input  logic [31:0] frame_count,
   output logic        wr_en,
   output logic [31:0] din,
   output logic        frame_inc,
   output logic        busy,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_GAP
   } state_t;

   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam bit          NO_GAP   = (GAP_CYCLES == 0);

   state_t      state_q, state_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] stall_inc;
   logic [15:0] fc_lo;
   logic        unused_fc_hi;

   assign fc_lo        = frame_count[15:0];
   assign unused_fc_hi = ^frame_count[31:16];
   assign stall_cnt    = stall_cnt_q;

   // Saturating increment so a long stall never wraps back to a small count
   assign stall_inc = (stall_cnt_q == 32'hFFFF_FFFF) ?
                      stall_cnt_q : stall_cnt_q + 32'd1;

   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      gap_cnt_d   = gap_cnt_q;
      stall_cnt_d = stall_cnt_q;
      wr_en       = 1'b0;
      frame_inc   = 1'b0;
      din         = '0;
      busy        = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_HDR;
         end
         S_HDR: begin
            din   = {HDR_TAG, fc_lo};
            wr_en = !full;
            if (full) begin
               stall_cnt_d = stall_inc;
            end else begin
               word_idx_d = '0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            din   = {fc_lo, word_idx_q};
            wr_en = !full;
            if (full) begin
               stall_cnt_d = stall_inc;
            end else begin
               word_idx_d = word_idx_q + 16'd1;
               if (word_idx_q == LAST_IDX) begin
                  frame_inc = 1'b1;
                  if (NO_GAP) begin
                     state_d = run ? S_HDR : S_IDLE;
                  end else begin
                     state_d   = S_GAP;
                     gap_cnt_d = '0;
                  end
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = run ? S_HDR : S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes are masked during reset even before the state flop clears
      if (rst) begin
         wr_en     = 1'b0;
         frame_inc = 1'b0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         word_idx_q  <= '0;
         gap_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         gap_cnt_q   <= gap_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
